// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and width helpers for the UART receive subsystem.
//   rx_state_t      : receiver FSM states
//   cnt_width()     : bits needed for a counter holding 0..n-1 (minimum 1)
//   fifo_cnt_width(): bits needed for an occupancy value 0..depth
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Serial pin plus host read/status port of the UART receive subsystem.
//   rx          : serial input, idles high
//   rd_uart     : pop the FIFO head
//   clr_err     : clear sticky error flags
//   R_data      : FIFO head (show-ahead)
//   rx_empty    : FIFO empty
//   rx_full     : FIFO full
//   rx_count    : FIFO occupancy 0..FIFO_DEPTH
//   frame_err   : sticky, stop bit sampled low
//   parity_err  : sticky, parity mismatch
//   overrun_err : sticky, frame completed while FIFO full
// Modports: master = host/pin side, slave = receiver.
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                                           rx;
    logic                                           rd_uart;
    logic                                           clr_err;
    logic [DATA_WIDTH-1:0]                          R_data;
    logic                                           rx_empty;
    logic                                           rx_full;
    logic [uart_pkg::fifo_cnt_width(FIFO_DEPTH)-1:0] rx_count;
    logic                                           frame_err;
    logic                                           parity_err;
    logic                                           overrun_err;

    modport master (
        output rx, rd_uart, clr_err,
        input  R_data, rx_empty, rx_full, rx_count,
        input  frame_err, parity_err, overrun_err
    );

    modport slave (
        input  rx, rd_uart, clr_err,
        output R_data, rx_empty, rx_full, rx_count,
        output frame_err, parity_err, overrun_err
    );
endinterface

// File: rtl/uart_fifo_sync.sv
// -----------------------------------------------------------------------------
// uart_fifo_sync
// Single-clock show-ahead FIFO. dout is a register that always holds the
// entry at the read pointer, so the head is visible without a read strobe.
//   UCLK, reset : clock, asynchronous active-high reset
//   wr, din     : write strobe and data (dropped when full unless rd too)
//   rd          : pop head (ignored when empty)
//   dout        : head entry, valid while empty=0
//   empty, full : status from an extra pointer wrap bit
//   count       : occupancy 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_fifo_sync
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                 UCLK,
    input  logic                                 reset,
    input  logic                                 wr,
    input  logic                                 rd,
    input  logic [DATA_WIDTH-1:0]                din,
    output logic [DATA_WIDTH-1:0]                dout,
    output logic                                 empty,
    output logic                                 full,
    output logic [fifo_cnt_width(FIFO_DEPTH)-1:0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_dout;

    logic        w_empty;
    logic        w_full;
    logic        w_rd_en;
    logic        w_wr_en;
    logic [AW:0] w_rd_ptr_next;

    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_rd_en       = rd && !w_empty;
    // A same-cycle pop frees a slot, so a write into a full FIFO still lands.
    assign w_wr_en       = wr && (!w_full || w_rd_en);
    assign w_rd_ptr_next = r_rd_ptr + {{AW{1'b0}}, w_rd_en};

    always_ff @(posedge UCLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_dout   <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_next;
            // The next head may be the word being written this cycle
            // (empty FIFO, or a pop leaving exactly the new entry): bypass it.
            if (w_wr_en && (r_wr_ptr[AW-1:0] == w_rd_ptr_next[AW-1:0])) begin
                r_dout <= din;
            end else begin
                r_dout <= r_mem[w_rd_ptr_next[AW-1:0]];
            end
        end
    end

    assign dout  = r_dout;
    assign empty = w_empty;
    assign full  = w_full;
    assign count = r_wr_ptr - r_rd_ptr;
endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Single-clock UART receiver: free-running oversample tick divider, 2-flop
// input synchroniser, oversampling receive FSM, sticky error flags and a
// show-ahead receive FIFO (uart_fifo_sync).
//   UCLK  : clock, all logic on rising edge
//   reset : asynchronous active-high reset
//   bus   : uart_rx_fifo_if.slave (rx pin, host read port, status, errors)
// Optional feature: define UART_RX_PARITY_EN to receive and check a parity
// bit after the data bits (PARITY_ODD selects odd/even). Without it there is
// no parity phase and parity_err is constant 0.
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DIVISOR    = 163,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic          UCLK,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);
    localparam int DIV_W = cnt_width(DIVISOR);
    localparam int S_W   = cnt_width(OVERSAMPLE);
    localparam int B_W   = cnt_width(DATA_WIDTH);
    localparam int CNT_W = fifo_cnt_width(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIVISOR - 1);
    localparam logic [S_W-1:0]   S_HALF      = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_LAST      = S_W'(OVERSAMPLE - 1);
    localparam logic [B_W-1:0]   B_DATA_LAST = B_W'(DATA_WIDTH - 1);
    localparam logic [B_W-1:0]   B_STOP_LAST = B_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD     = 1'(PARITY_ODD);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    // synchroniser and tick
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    // receiver FSM
    rx_state_t             r_state,  w_state_next;
    logic [S_W-1:0]        r_s,      w_s_next;
    logic [B_W-1:0]        r_nbit,   w_nbit_next;
    logic [DATA_WIDTH-1:0] r_shift,  w_shift_next;
    logic                  r_bad,    w_bad_next;
    logic                  w_par_mismatch;
    logic                  w_last_stop;
    logic                  w_frame_set;
    logic                  w_frame_good;
    logic                  r_wr;

    // FIFO and flags
    logic [DATA_WIDTH-1:0] w_dout;
    logic                  w_empty;
    logic                  w_full;
    logic [CNT_W-1:0]      w_count;
    logic                  w_ovr_set;
    logic                  r_frame_err;
    logic                  r_overrun_err;

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Free-running: a start bit does not re-phase the tick.
    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Parity over data plus received parity bit: 1 for odd total ones.
    assign w_par_mismatch = ((^r_shift) ^ r_rx_s) != PAR_ODD;

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_nbit  <= '0;
            r_shift <= '0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_nbit  <= w_nbit_next;
            r_shift <= w_shift_next;
            r_bad   <= w_bad_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_nbit_next  = r_nbit;
        w_shift_next = r_shift;
        w_bad_next   = r_bad;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        w_state_next = START;
                        w_s_next     = '0;
                    end
                end
                START: begin
                    if (r_s == S_HALF) begin
                        w_s_next    = '0;
                        w_nbit_next = '0;
                        w_bad_next  = 1'b0;
                        // Line back high at mid start bit: treat as a glitch.
                        w_state_next = r_rx_s ? IDLE : DATA;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
                DATA: begin
                    if (r_s == S_LAST) begin
                        w_s_next     = '0;
                        w_shift_next = {r_rx_s, r_shift[DATA_WIDTH-1:1]};
                        if (r_nbit == B_DATA_LAST) begin
                            w_nbit_next  = '0;
                            w_state_next = AFTER_DATA;
                        end else begin
                            w_nbit_next = r_nbit + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
                PARITY: begin
                    if (r_s == S_LAST) begin
                        w_s_next     = '0;
                        w_nbit_next  = '0;
                        w_bad_next   = r_bad | w_par_mismatch;
                        w_state_next = STOP;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
                STOP: begin
                    if (r_s == S_LAST) begin
                        w_s_next   = '0;
                        w_bad_next = r_bad | !r_rx_s;
                        if (r_nbit == B_STOP_LAST) begin
                            w_nbit_next  = '0;
                            w_state_next = IDLE;
                        end else begin
                            w_nbit_next = r_nbit + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic w_par_set;
    logic r_parity_err;
`endif

    always_comb begin
        w_last_stop = 1'b0;
        w_frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_set   = 1'b0;
`endif
        if (w_tick && (r_s == S_LAST)) begin
            case (r_state)
                STOP: begin
                    w_last_stop = (r_nbit == B_STOP_LAST);
                    w_frame_set = !r_rx_s;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: w_par_set = w_par_mismatch;
`endif
                default: ;
            endcase
        end
        // r_bad holds earlier stop/parity failures; r_rx_s is this stop sample.
        w_frame_good = w_last_stop && r_rx_s && !r_bad;
    end

    // Write strobe lands the cycle after the last stop-sample tick.
    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_wr <= 1'b0;
        end else begin
            r_wr <= w_frame_good;
        end
    end

    uart_fifo_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .UCLK  (UCLK),
        .reset (reset),
        .wr    (r_wr),
        .rd    (bus.rd_uart),
        .din   (r_shift),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    assign w_ovr_set = r_wr && w_full && !bus.rd_uart;

    // Set has priority over clear so an error in the clearing cycle is kept.
    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_frame_set)      r_frame_err <= 1'b1;
            else if (bus.clr_err) r_frame_err <= 1'b0;
            if (w_ovr_set)        r_overrun_err <= 1'b1;
            else if (bus.clr_err) r_overrun_err <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else if (w_par_set) begin
            r_parity_err <= 1'b1;
        end else if (bus.clr_err) begin
            r_parity_err <= 1'b0;
        end
    end
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.R_data      = w_dout;
    assign bus.rx_empty    = w_empty;
    assign bus.rx_full     = w_full;
    assign bus.rx_count    = w_count;
    assign bus.frame_err   = r_frame_err;
    assign bus.overrun_err = r_overrun_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo (DIVISOR=4, OVERSAMPLE=16 -> 64 clocks
// per bit, 8 data bits, 1 stop bit, 16-entry FIFO, odd parity when the
// UART_RX_PARITY_EN build is used). Bytes expected to be stored are queued
// when their frame is driven and popped when the host reads them.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;
    localparam int DIVISOR    = 4;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_WIDTH = 8;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 16;
    localparam int PARITY_ODD = 1;
    localparam int BIT_CYC    = DIVISOR * OVERSAMPLE;

    logic clk   = 1'b0;
    logic rst   = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    uart_rx_fifo #(
        .DIVISOR    (DIVISOR),
        .OVERSAMPLE (OVERSAMPLE),
        .DATA_WIDTH (DATA_WIDTH),
        .STOP_BITS  (STOP_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .UCLK  (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sb_q [$];
    logic       exp_ferr = 1'b0;
    logic       exp_perr = 1'b0;
    logic       exp_ovr  = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        logic       clr_after;
        int         exp_count;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %-20s got=%0h want=%0h", name, act, exp);
        end else begin
            $display("  ok %-20s %0h", name, act);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; the scoreboard/flag model is updated as it is sent.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        logic par;
        par = (PARITY_ODD != 0) ? ~(^d) : (^d);
        bus.rx = 1'b0;
        cycles(BIT_CYC);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            bus.rx = d[i];
            cycles(BIT_CYC);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = par ^ par_flip;
        cycles(BIT_CYC);
        if (par_flip) exp_perr = 1'b1;
`else
        par = par ^ par_flip;
`endif
        for (int i = 0; i < STOP_BITS; i++) begin
            bus.rx = stop_v;
            // A low stop bit is shortened so the line is back high well
            // before a possible false start could pass its mid-bit check.
            cycles(stop_v ? BIT_CYC : (BIT_CYC * 3) / 4);
        end
        bus.rx = 1'b1;
        cycles(32);
        if (!stop_v) exp_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (stop_v && !par_flip) begin
`else
        if (stop_v) begin
`endif
            if (sb_q.size() < FIFO_DEPTH) sb_q.push_back(d);
            else exp_ovr = 1'b1;
        end
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        exp = sb_q.pop_front();
        check({name, " empty"}, 32'(bus.rx_empty), 32'h0);
        check({name, " data"}, 32'(bus.R_data), 32'(exp));
        bus.rd_uart = 1'b1;
        cycles(1);
        bus.rd_uart = 1'b0;
        cycles(1);
    endtask

    task automatic clear_errors();
        bus.clr_err = 1'b1;
        cycles(1);
        bus.clr_err = 1'b0;
        cycles(1);
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, " count"},   32'(bus.rx_count),    32'(sb_q.size()));
        check({tag, " empty"},   32'(bus.rx_empty),    32'(sb_q.size() == 0));
        check({tag, " full"},    32'(bus.rx_full),     32'(sb_q.size() == FIFO_DEPTH));
        check({tag, " ferr"},    32'(bus.frame_err),   32'(exp_ferr));
        check({tag, " perr"},    32'(bus.parity_err),  32'(exp_perr));
        check({tag, " overrun"}, 32'(bus.overrun_err), 32'(exp_ovr));
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, stop_v: 1'b1, clr_after: 1'b0, exp_count: 1, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h3C, stop_v: 1'b0, clr_after: 1'b1, exp_count: 1, exp_ferr: 1'b1};
        vecs[2] = '{data: 8'h5A, stop_v: 1'b1, clr_after: 1'b0, exp_count: 2, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'h00, stop_v: 1'b1, clr_after: 1'b0, exp_count: 3, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'hFF, stop_v: 1'b1, clr_after: 1'b0, exp_count: 4, exp_ferr: 1'b0};

        bus.rx      = 1'b1;
        bus.rd_uart = 1'b0;
        bus.clr_err = 1'b0;
        rst         = 1'b1;
        cycles(5);
        check("reset R_data", 32'(bus.R_data), 32'h0);
        check_status("reset");
        rst = 1'b0;
        cycles(5);

        // Table-driven frames, including a bad stop bit and error clear.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_v, 1'b0);
            check($sformatf("vec%0d count", i), 32'(bus.rx_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d ferr", i), 32'(bus.frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d head", i), 32'(bus.R_data), 32'h0000_00A5);
            if (vecs[i].clr_after) begin
                clear_errors();
                check($sformatf("vec%0d ferr clr", i), 32'(bus.frame_err), 32'h0);
            end
        end
        while (sb_q.size() > 0) pop_check("drain");
        check_status("drained");

        // rd_uart while empty: no effect, no error.
        bus.rd_uart = 1'b1;
        cycles(1);
        bus.rd_uart = 1'b0;
        cycles(1);
        check_status("rd empty");

        // Short low pulse on rx must be rejected as a glitch.
        bus.rx = 1'b0;
        cycles(20);
        bus.rx = 1'b1;
        cycles(700);
        check_status("glitch");

        // 17 frames with no reads: last one overruns.
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
        check_status("overrun");
        check("overrun full", 32'(bus.rx_full), 32'h1);
        while (sb_q.size() > 0) pop_check("ovr pop");
        check_status("ovr drained");
        clear_errors();
        check("ovr clr", 32'(bus.overrun_err), 32'h0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0);
        check_status("par good");
        send_frame(8'h01, 1'b1, 1'b1);
        check_status("par bad");
        pop_check("par pop");
        clear_errors();
        check_status("par clr");
`endif

        // Reset during a frame, with a stored byte and a sticky error.
        send_frame(8'h77, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        check_status("pre reset");
        bus.rx = 1'b0;
        cycles(BIT_CYC);
        bus.rx = 1'b1;
        cycles(3 * BIT_CYC);
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        sb_q.delete();
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        exp_ovr  = 1'b0;
        cycles(10);
        check_status("post reset");
        send_frame(8'h12, 1'b1, 1'b0);
        check_status("after reset");
        pop_check("reset pop");
        check_status("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
